// File: rtl/mult_wb_buffer.sv
// Result buffer between the multiplier and writeback.
// Holds up to DEPTH {trans_id, result} entries in a circular FIFO and only
// lets the issue stage start a multiply when the result has a guaranteed slot,
// counting the op still inside the one-cycle multiplier.
// A flush empties the FIFO; if an op is still inside the multiplier when the
// flush arrives, a one-cycle DRAIN state discards its late result.
module mult_wb_buffer #(
    parameter int XLEN          = 32,
    parameter int TRANS_ID_BITS = 3,
    parameter int DEPTH         = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic                     flush_i,
    input  logic                     mult_valid_i,
    input  logic [TRANS_ID_BITS-1:0] mult_trans_id_i,
    input  logic [XLEN-1:0]          mult_result_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [XLEN-1:0]          wb_result_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [TRANS_ID_BITS-1:0] id_mem  [DEPTH];
    logic [XLEN-1:0]          res_mem [DEPTH];

    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          inflight_q;
    logic          err_q;
    logic [0:0]    state_q;

    logic [CW:0]   occupancy;
    logic          full;
    logic          accept;
    logic          pop;
    logic          push;
    logic          live_result;
    logic          err_set;

    // Handshake decode: occupancy includes the op still in the multiplier.
    always_comb begin
        occupancy     = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
        full          = (cnt_q == FULL);
        issue_ready_o = (occupancy < {1'b0, FULL}) && (state_q == RUN) &&
                        !flush_i && !rst_i;
        accept        = issue_valid_i && issue_ready_o;
        wb_valid_o    = (cnt_q != '0);
        pop           = wb_valid_o && wb_ready_i;
        // A result only counts while running and not being flushed away.
        live_result   = mult_valid_i && (state_q == RUN) && !flush_i;
        push          = live_result && (!full || pop);
        // Unexpected result, or a result that arrives with nowhere to go.
        err_set       = live_result && (!inflight_q || (full && !pop));
    end

    assign wb_result_o   = res_mem[rd_ptr_q];
    assign wb_trans_id_o = id_mem[rd_ptr_q];
    assign count_o       = cnt_q;
    assign err_o         = err_q;

    // Entry storage: written at the write pointer on every push.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_mem[i]  <= '0;
                res_mem[i] <= '0;
            end
        end else if (push) begin
            id_mem[wr_ptr_q]  <= mult_trans_id_i;
            res_mem[wr_ptr_q] <= mult_result_i;
        end
    end

    // Control: pointers, occupancy, in-flight tracking, error flag and FSM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            state_q    <= RUN;
        end else begin
            // accept is already forced low by flush_i, which clears the op.
            inflight_q <= accept;
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
                // Only an op whose result has not shown up yet needs draining.
                if ((state_q == RUN) && inflight_q && !mult_valid_i) begin
                    state_q <= DRAIN;
                end else begin
                    state_q <= RUN;
                end
            end else begin
                // DRAIN lasts exactly one cycle: the multiplier latency is 1.
                state_q <= RUN;
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                if (push && !pop) begin
                    cnt_q <= cnt_q + CW'(1);
                end else if (pop && !push) begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_wb_buffer.sv
// Directed testbench for mult_wb_buffer (XLEN=32, TRANS_ID_BITS=3, DEPTH=4).
// Inputs change 1 time unit after each rising edge; outputs are checked
// 2 time units after the edge.
module tb_mult_wb_buffer;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic        flush;
    logic        mult_valid;
    logic [2:0]  mult_id;
    logic [31:0] mult_res;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_res;
    logic [2:0]  wb_id;
    logic [2:0]  count;
    logic        err;

    int checks;
    int errors;

    mult_wb_buffer #(
        .XLEN          (32),
        .TRANS_ID_BITS (3),
        .DEPTH         (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .issue_valid_i   (issue_valid),
        .issue_ready_o   (issue_ready),
        .flush_i         (flush),
        .mult_valid_i    (mult_valid),
        .mult_trans_id_i (mult_id),
        .mult_result_i   (mult_res),
        .wb_valid_o      (wb_valid),
        .wb_ready_i      (wb_ready),
        .wb_result_o     (wb_res),
        .wb_trans_id_o   (wb_id),
        .count_o         (count),
        .err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  exp_id  [4];
        logic [31:0] exp_res [4];

        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        issue_valid = 1'b0;
        flush       = 1'b0;
        mult_valid  = 1'b0;
        mult_id     = '0;
        mult_res    = '0;
        wb_ready    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_count",       32'(count),       32'd0);
        check("rst_wb_valid",    32'(wb_valid),    32'd0);
        check("rst_issue_ready", 32'(issue_ready), 32'd0);
        check("rst_err",         32'(err),         32'd0);
        check("rst_wb_res",      wb_res,           32'd0);
        check("rst_wb_id",       32'(wb_id),       32'd0);

        // Single op: issue, result one cycle later, writeback one cycle after that
        rst = 1'b0; issue_valid = 1'b1; wb_ready = 1'b1;
        #1;
        check("s1_ready_after_rst", 32'(issue_ready), 32'd1);
        next_cycle();
        issue_valid = 1'b0; mult_valid = 1'b1; mult_id = 3'd3; mult_res = 32'h0000_00FF;
        #1;
        check("s1_no_bypass", 32'(wb_valid), 32'd0);
        next_cycle();
        mult_valid = 1'b0;
        #1;
        check("s1_wb_valid", 32'(wb_valid), 32'd1);
        check("s1_wb_id",    32'(wb_id),    32'd3);
        check("s1_wb_res",   wb_res,        32'h0000_00FF);
        check("s1_count1",   32'(count),    32'd1);
        next_cycle();
        #1;
        check("s1_count0",    32'(count),    32'd0);
        check("s1_wb_idle",   32'(wb_valid), 32'd0);
        check("s1_err_clear", 32'(err),      32'd0);

        // Backpressure: four issues back to back with writeback stalled
        wb_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            issue_valid = (c < 4);
            mult_valid  = (c >= 1);
            mult_id     = 3'(c);
            mult_res    = 32'hA0 + 32'(c);
            #1;
            check("s2_issue_ready", 32'(issue_ready), (c < 4) ? 32'd1 : 32'd0);
        end
        next_cycle();
        issue_valid = 1'b0; mult_valid = 1'b0; wb_ready = 1'b1;
        #1;
        check("s2_count_full",  32'(count),       32'd4);
        check("s2_ready_full",  32'(issue_ready), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            check("s2_drain_valid", 32'(wb_valid), 32'd1);
            check("s2_drain_id",    32'(wb_id),    32'(k));
            check("s2_drain_res",   wb_res,        32'hA0 + 32'(k));
            next_cycle();
            #1;
        end
        check("s2_count_empty", 32'(count),    32'd0);
        check("s2_wb_idle",     32'(wb_valid), 32'd0);

        // Flush with one op in flight: DRAIN swallows the late result
        next_cycle();
        issue_valid = 1'b1;
        #1;
        check("s3_ready_run", 32'(issue_ready), 32'd1);
        next_cycle();
        issue_valid = 1'b0; flush = 1'b1;
        #1;
        check("s3_ready_flush", 32'(issue_ready), 32'd0);
        next_cycle();
        flush = 1'b0; mult_valid = 1'b1; mult_id = 3'd5; mult_res = 32'h55;
        #1;
        check("s3_ready_drain", 32'(issue_ready), 32'd0);
        next_cycle();
        mult_valid = 1'b0;
        #1;
        check("s3_count",    32'(count),       32'd0);
        check("s3_wb_valid", 32'(wb_valid),    32'd0);
        check("s3_err",      32'(err),         32'd0);
        check("s3_run",      32'(issue_ready), 32'd1);

        // Flush coinciding with the result: discarded, no DRAIN, no error
        next_cycle();
        issue_valid = 1'b1;
        next_cycle();
        issue_valid = 1'b0; flush = 1'b1; mult_valid = 1'b1; mult_id = 3'd6; mult_res = 32'h66;
        next_cycle();
        flush = 1'b0; mult_valid = 1'b0;
        #1;
        check("s3b_count", 32'(count),       32'd0);
        check("s3b_err",   32'(err),         32'd0);
        check("s3b_run",   32'(issue_ready), 32'd1);

        // Protocol error: result without an issue; still pushed, flag is sticky
        next_cycle();
        wb_ready = 1'b0; mult_valid = 1'b1; mult_id = 3'd2; mult_res = 32'hDEAD_BEEF;
        #1;
        check("s4_err_before", 32'(err), 32'd0);
        next_cycle();
        mult_valid = 1'b0; wb_ready = 1'b1;
        #1;
        check("s4_err_set", 32'(err),   32'd1);
        check("s4_count",   32'(count), 32'd1);
        check("s4_wb_id",   32'(wb_id), 32'd2);
        check("s4_wb_res",  wb_res,     32'hDEAD_BEEF);
        next_cycle();
        wb_ready = 1'b0;
        #1;
        check("s4_count0", 32'(count), 32'd0);
        repeat (3) next_cycle();
        #1;
        check("s4_err_sticky", 32'(err), 32'd1);

        // Full FIFO: drop without pop, then push+pop while full wraps pointers
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            mult_valid = 1'b1; mult_id = 3'(k); mult_res = 32'hC0 + 32'(k);
        end
        next_cycle();
        mult_valid = 1'b1; mult_id = 3'd7; mult_res = 32'h77;
        #1;
        check("s5_full",       32'(count),       32'd4);
        check("s5_ready_full", 32'(issue_ready), 32'd0);
        next_cycle();
        mult_valid = 1'b1; mult_id = 3'd6; mult_res = 32'h88; wb_ready = 1'b1;
        #1;
        check("s5_after_drop", 32'(count), 32'd4);
        check("s5_head_id",    32'(wb_id),  32'd1);
        check("s5_head_res",   wb_res,      32'hC1);
        next_cycle();
        mult_valid = 1'b0;
        #1;
        check("s5_pushpop_count", 32'(count), 32'd4);
        exp_id  = '{3'd2, 3'd3, 3'd4, 3'd6};
        exp_res = '{32'hC2, 32'hC3, 32'hC4, 32'h88};
        for (int k = 0; k < 4; k++) begin
            check("s5_order_id",  32'(wb_id), 32'(exp_id[k]));
            check("s5_order_res", wb_res,     exp_res[k]);
            next_cycle();
            #1;
        end
        check("s5_count0", 32'(count),    32'd0);
        check("s5_idle",   32'(wb_valid), 32'd0);

        // Asynchronous reset with two entries buffered
        wb_ready = 1'b0;
        next_cycle();
        mult_valid = 1'b1; mult_id = 3'd1; mult_res = 32'h11;
        next_cycle();
        mult_id = 3'd2; mult_res = 32'h22;
        next_cycle();
        mult_valid = 1'b0;
        #1;
        check("s6_count2", 32'(count),    32'd2);
        check("s6_valid",  32'(wb_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("s6_async_count", 32'(count),       32'd0);
        check("s6_async_valid", 32'(wb_valid),    32'd0);
        check("s6_async_ready", 32'(issue_ready), 32'd0);
        check("s6_async_err",   32'(err),         32'd0);
        check("s6_async_res",   wb_res,           32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("s6_ready_after", 32'(issue_ready), 32'd1);
        next_cycle();
        #1;
        check("s6_no_wb",    32'(wb_valid), 32'd0);
        check("s6_count_lo", 32'(count),    32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_wb_buffer.md
MULT_WB_BUFFER -- requirements
Module: mult_wb_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of the multiplier result.
REQ-002 SHALL have parameter TRANS_ID_BITS, default 3: width of the transaction ID.
REQ-003 SHALL have parameter DEPTH, default 4, power of two, at least 2: number of result entries.
REQ-004 clk_i  in  1  sole clock; all state rising-edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 issue_valid_i  in  1  issue stage presents a multiply-class op to the multiplier this cycle.
REQ-007 issue_ready_o  out  1  buffer guarantees space for that op's result.
REQ-008 flush_i  in  1  kill all buffered and in-flight results.
REQ-009 mult_valid_i  in  1  multiplier result valid (1 cycle after the issue).
REQ-010 mult_trans_id_i  in  TRANS_ID_BITS  ID of the result.
REQ-011 mult_result_i  in  XLEN  result word.
REQ-012 wb_valid_o  out  1  head entry valid toward writeback.
REQ-013 wb_ready_i  in  1  writeback accepts head entry.
REQ-014 wb_result_o  out  XLEN  head entry result.
REQ-015 wb_trans_id_o  out  TRANS_ID_BITS  head entry ID.
REQ-016 count_o  out  clog2(DEPTH)+1  number of occupied entries.
REQ-017 err_o  out  1  sticky protocol-error flag.

Function
REQ-018 Storage SHALL be a circular FIFO of DEPTH {trans_id, result} entries, with read and write pointers wrapping modulo DEPTH.
REQ-019 Issue accept SHALL be issue_valid_i AND issue_ready_o; inflight_q SHALL load the accept value every cycle.
REQ-020 issue_ready_o SHALL be (count + inflight_q) < DEPTH AND state==RUN AND NOT flush_i, computed combinationally.
REQ-021 Push SHALL occur when mult_valid_i is high, state==RUN, flush_i is low, and (count<DEPTH OR pop in the same cycle).
REQ-022 Pop SHALL occur when wb_valid_o AND wb_ready_i.
REQ-023 wb_valid_o SHALL be count!=0; wb_result_o and wb_trans_id_o SHALL come from the read-pointer entry; there is no bypass, so the minimum latency from mult_valid_i to wb_valid_o is 1 cycle.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and advance both pointers, including when count==DEPTH.
REQ-025 When count==0, wb_valid_o SHALL be 0 and wb_result_o/wb_trans_id_o SHALL hold the stale head contents, which are 0 after reset.
REQ-026 mult_valid_i high while inflight_q==0 SHALL set err_o; the result is still pushed if space allows.
REQ-027 mult_valid_i high with count==DEPTH and no pop SHALL set err_o; the result is dropped and the FIFO is unchanged.
REQ-028 err_o SHALL clear only on reset.
REQ-029 State machine: RUN and DRAIN.
REQ-030 RUN -> DRAIN on flush_i when inflight_q==1 and mult_valid_i==0 in that cycle; otherwise flush_i stays in RUN.
REQ-031 flush_i in any state SHALL zero count and both pointers next cycle; a pop in the flush cycle has no effect beyond the flush.
REQ-032 A mult_valid_i coinciding with flush_i SHALL be discarded without setting err_o.
REQ-033 DRAIN: issue_ready_o=0; the next mult_valid_i SHALL be discarded (no push, no err_o), then -> RUN.
REQ-034 DRAIN with mult_valid_i==0 SHALL -> RUN after one cycle, because the multiplier latency is exactly 1.
REQ-035 inflight_q SHALL be cleared by flush_i.
REQ-036 count_o SHALL equal the registered count.

Reset
REQ-037 While rst_i is high, all of the following SHALL hold:
  - count, pointers, inflight_q and err_o are 0;
  - state is RUN;
  - entry storage is 0;
  - wb_valid_o is 0;
  - issue_ready_o is 0.
REQ-038 After rst_i deasserts, issue_ready_o SHALL be 1 in the first cycle.
REQ-039 Reset asserted mid-operation SHALL discard all buffered and in-flight results immediately, with no writeback.

Verification
REQ-040 Single op: issue at cycle 0; mult_valid_i at cycle 1 with id=3 and result=0x0000_00FF; wb_ready_i=1 -> wb_valid_o at cycle 2 carrying id=3 and 0xFF, then count_o=0 at cycle 3.
REQ-041 Backpressure: wb_ready_i=0; 4 issues, one per cycle -> issue_ready_o drops in the cycle after the 4th accept; count_o reaches 4; raising wb_ready_i drains the entries in issue order.
REQ-042 Full plus simultaneous push/pop: count=4 with a pop and mult_valid_i in the same cycle -> count stays 4, the pointers wrap, and err_o stays 0.
REQ-043 Flush with one op in flight: flush_i in the cycle after the issue's accept -> DRAIN; the following mult_valid_i is discarded; RUN returns with count_o=0 and err_o=0.
REQ-044 Protocol error: mult_valid_i with no prior issue -> err_o=1 and stays 1 until rst_i.
REQ-045 Async reset pulse while count=2 -> count_o=0 and wb_valid_o=0 immediately, with no clock edge required.
